// File: rtl/nr_pkg.sv
// Shared types and helpers for the Newton/bisection root iterator.
package nr_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;

    localparam int DEF_W      = 32;
    localparam int DEF_ITERS  = 300;
    localparam int DEF_COEF_A = 2;
    localparam int DEF_COEF_C = 100;

    // Signed divide by 2**k rounding toward zero (a bare >>> rounds down).
    function automatic logic signed [63:0] sdiv_pow2(
        input logic signed [63:0] v,
        input int unsigned        k
    );
        logic signed [63:0] bias;
        bias = v[63] ? ((64'sd1 <<< k) - 64'sd1) : 64'sd0;
        return (v + bias) >>> k;
    endfunction

endpackage

// File: rtl/nr_step.sv
// One hybrid Newton/bisection iteration: bracket update and next estimate.
module nr_step
    import nr_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic signed [W-1:0] rts,
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] xh,
    input  logic signed [W-1:0] f,
    input  logic signed [W-1:0] df,
    output logic signed [W-1:0] new_rts,
    output logic signed [W-1:0] new_x1,
    output logic signed [W-1:0] new_xh
);

    logic signed [W-1:0] lo;
    logic signed [W-1:0] hi;
    logic signed [W-1:0] pa;
    logic signed [W-1:0] pb;
    logic signed [W-1:0] p;
    logic signed [W-1:0] span;
    logic signed [W-1:0] half;
    logic signed [W-1:0] quarter;
    logic                bisect;

    assign lo = f[W-1] ? rts : x1;
    assign hi = f[W-1] ? xh  : rts;

    assign pa   = (rts - lo) * df - f;
    assign pb   = (rts - hi) * df - f;
    assign p    = pa * pb;
    assign span = hi - lo;

    assign half    = W'(sdiv_pow2(64'(span), 1));
    assign quarter = W'(sdiv_pow2(64'(rts), 2));

    // Newton step leaves the bracket: fall back to bisection.
    assign bisect = p[W-1] || (p == '0);

    assign new_rts = bisect ? (lo + half) : (rts - quarter);
    assign new_x1  = lo;
    assign new_xh  = hi;

endmodule

// File: rtl/nr_iter_engine.sv
// Bracketed Newton root iterator for A*x*x - C behind a start/end handshake.
module nr_iter_engine
    import nr_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int ITERS      = DEF_ITERS,
    parameter int COEF_A     = DEF_COEF_A,
    parameter int COEF_C     = DEF_COEF_C,
    parameter int EARLY_EXIT = 0,
    parameter int CNT_W      = $clog2(ITERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic signed [W-1:0] rts_din,
    input  logic signed [W-1:0] x1_din,
    input  logic signed [W-1:0] xh_din,
    input  logic [CNT_W-1:0]    limit_din,
    output logic                end_valid,
    input  logic                end_ready,
    output logic signed [W-1:0] end_out,
    output logic [CNT_W-1:0]    end_iters
);

    localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(ITERS);
    localparam logic signed [W-1:0] K_A     = W'(COEF_A);
    localparam logic signed [W-1:0] K_2A    = W'(2 * COEF_A);
    localparam logic signed [W-1:0] K_C     = W'(COEF_C);

    state_t              state;
    logic signed [W-1:0] rts;
    logic signed [W-1:0] x1;
    logic signed [W-1:0] xh;
    logic signed [W-1:0] f;
    logic signed [W-1:0] df;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    lim;

    logic signed [W-1:0] new_rts;
    logic signed [W-1:0] new_x1;
    logic signed [W-1:0] new_xh;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    lim_sel;
    logic                stop;

    nr_step #(.W(W)) u_step (
        .rts     (rts),
        .x1      (x1),
        .xh      (xh),
        .f       (f),
        .df      (df),
        .new_rts (new_rts),
        .new_x1  (new_x1),
        .new_xh  (new_xh)
    );

    assign cnt_next = cnt + 1'b1;

    // Zero and anything past ITERS both mean "run the full budget".
    assign lim_sel = ((limit_din == '0) || (limit_din > MAX_CNT)) ?
                     MAX_CNT : limit_din;

    assign stop = (cnt_next == lim) ||
                  ((EARLY_EXIT != 0) && (new_rts == rts));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            start_ready <= 1'b0;
            end_valid   <= 1'b0;
            end_out     <= '0;
            end_iters   <= '0;
            rts         <= '0;
            x1          <= '0;
            xh          <= '0;
            f           <= '0;
            df          <= '0;
            cnt         <= '0;
            lim         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    start_ready <= 1'b1;
                    if (start_valid && start_ready) begin
                        rts         <= rts_din;
                        x1          <= x1_din;
                        xh          <= xh_din;
                        lim         <= lim_sel;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        state       <= EVAL;
                    end
                end
                EVAL: begin
                    f     <= K_A * rts * rts - K_C;
                    df    <= K_2A * rts;
                    state <= UPDATE;
                end
                UPDATE: begin
                    cnt   <= cnt_next;
                    rts   <= new_rts;
                    x1    <= new_x1;
                    xh    <= new_xh;
                    state <= stop ? DONE : EVAL;
                end
                DONE: begin
                    if (!end_valid) begin
                        end_valid <= 1'b1;
                        end_out   <= rts;
                        end_iters <= cnt;
                    end else if (end_ready) begin
                        end_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nr_iter_engine.md
Name: nr_iter_engine

Overview:
- Parametrised hybrid Newton/bisection root iterator for f(x) = COEF_A*x*x - COEF_C. Derivative is df = 2*COEF_A*x.
- Next-generation replacement for the fixed 32-bit, fixed-300-iteration newton_graph kernel. Adds configurable width, coefficients, runtime iteration limit, optional early exit, and an iteration-count output.
- Sits behind the dataflow start/end handshake used by the graph kernels.

Parameters:
- W, 32, data width (signed two's complement).
- ITERS, 300, maximum iteration count.
- COEF_A, 2, quadratic coefficient.
- COEF_C, 100, constant term.
- EARLY_EXIT, 0, when 1, terminate once an iteration leaves rts unchanged.
- CNT_W, $clog2(ITERS+1), iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start_valid  in  1  job request.
- start_ready  out  1  engine idle and able to accept a job.
- rts_din  in  W  initial estimate, sampled on start accept.
- x1_din  in  W  initial low bracket, sampled on start accept.
- xh_din  in  W  initial high bracket, sampled on start accept.
- limit_din  in  CNT_W  iteration limit, sampled on start accept. 0 means ITERS; values above ITERS are clamped to ITERS.
- end_valid  out  1  result available.
- end_ready  in  1  consumer accepts result.
- end_out  out  W  final rts.
- end_iters  out  CNT_W  number of iterations executed.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; start_ready=0 while asserted, then 1 in IDLE; end_valid=0, end_out=0, end_iters=0; all internal registers 0. Asserting reset mid-job aborts the job; no result is produced.
- FSM states: IDLE, EVAL, UPDATE, DONE.
- IDLE:
  - start_ready=1.
  - start_valid&&start_ready: latch rts/x1/xh/limit, cnt=0, go to EVAL.
- EVAL:
  - Register df = 2*COEF_A*rts and f = COEF_A*rts*rts - COEF_C.
  - Go to UPDATE.
- UPDATE (one iteration):
  - cnt++.
  - If f<0 then x1=rts, else xh=rts (new bracket used below).
  - p = ((rts-x1)*df - f) * ((rts-xh)*df - f).
  - If p<=0: dx=(xh-x1)/2 and rts=x1+dx.
  - Else: dx=rts/4 and rts=rts-dx.
  - Terminate to DONE if cnt==limit, or if EARLY_EXIT=1 and the new rts equals the old rts. Otherwise go to EVAL.
- DONE:
  - end_valid=1; end_out=rts; end_iters=cnt. These are held stable while end_ready=0.
  - end_valid&&end_ready: go to IDLE; end_valid drops next cycle.
- Arithmetic:
  - Every intermediate is truncated to W bits, wrapping modulo 2^W.
  - Comparisons are signed on the truncated value. This matches C int semantics when W=32.
  - Division by 2 and by 4 is signed, truncating toward zero. It is not an arithmetic shift: -3/4 = 0.
- Latency:
  - Start accepted at edge k; end_valid=1 after edge k+2N+1, where N is the number of iterations executed.
  - Throughput: one job in flight; start_ready=0 from EVAL through DONE.
- Handshake rules:
  - start_valid is ignored outside IDLE.
  - din ports are don't-care except in the accept cycle.
  - A job and a result cannot be exchanged in the same cycle. The next start is earliest the cycle after end handshake.
- limit_din:
  - limit_din=1 executes exactly one iteration.
  - The counter never wraps, since cnt<=ITERS by clamping.

Decomposition:
- Package nr_pkg: state enum (IDLE, EVAL, UPDATE, DONE); default constants W=32, ITERS=300, COEF_A=2, COEF_C=100; function for signed truncating division by powers of two.
- Sub-module nr_step: combinational UPDATE datapath. It takes rts, x1, xh, f, df and returns new rts, x1, xh. It is parametrised by W. The FSM and registers stay in nr_iter_engine.

Test Plan:
- W=32, ITERS=300, EARLY_EXIT=0, limit=0, rts=x1=xh=3 -> end_out=3, end_iters=300, end_valid exactly 601 cycles after accept.
- Same configuration, rts=x1=xh=-3 -> end_out=-3. Confirms truncating division; an arithmetic shift would give a different result. end_iters=300.
- EARLY_EXIT=1, rts=8, x1=0, xh=16, limit=0 -> trace 8→4→3→3. Requires end_out=3, end_iters=3.
- Same inputs with limit=1 -> end_out=4, end_iters=1. With limit=500 -> clamped, identical to the limit=300 result.
- Backpressure: hold end_ready=0 for 20 cycles in DONE -> end_valid/end_out/end_iters stable, start_ready=0, start_valid pulses ignored. Then release end_ready -> one handshake, start_ready=1 next cycle.
- Drive rst=0 asynchronously mid-EVAL of a 300-iteration job -> outputs 0 immediately, no end_valid. The next job, rts=x1=xh=3, returns 3 correctly.
